// File: rtl/mbus_pkg.sv
// Shared types and widths for the multiplexed-bus master.
package mbus_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int WCNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4
  } state_e;

endpackage

// File: rtl/mbus_if.sv
// Core request/response handshake plus the muxed address/data bus pins.
interface mbus_if;
  import mbus_pkg::*;

  logic              req;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] ad_o;
  logic [DATA_W-1:0] ad_i;
  logic              ad_lo_oe;
  logic              ad_hi_oe;
  logic              ale;
  logic              oe_n;
  logic              we_n;
  logic              pio;

  modport master (
    input  req, req_we, req_addr, req_wdata, ad_i,
    output busy, done, rdata, ad_o, ad_lo_oe, ad_hi_oe, ale, oe_n, we_n, pio
  );

  modport slave (
    output req, req_we, req_addr, req_wdata, ad_i,
    input  busy, done, rdata, ad_o, ad_lo_oe, ad_hi_oe, ale, oe_n, we_n, pio
  );

endinterface

// File: rtl/mbus_wait_cnt.sv
// Wait-state down-counter: load at T3 entry, decrement each extra T3 cycle.
module mbus_wait_cnt
  import mbus_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WCNT_W-1:0] load_val,
  input  logic              dec,
  output logic              zero
);

  logic [WCNT_W-1:0] cnt_q;
  logic [WCNT_W-1:0] cnt_d;

  // Load has priority; decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != {WCNT_W{1'b0}})) begin
      cnt_d = cnt_q - WCNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {WCNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == {WCNT_W{1'b0}});

endmodule

// File: rtl/mbus_master.sv
// Four-phase (T1..T4) multiplexed address/data bus master with programmable wait states.
module mbus_master
  import mbus_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
)(
  input  logic   clk,
  input  logic   rst_n,
  mbus_if.master bus
);

  localparam logic [WCNT_W-1:0] WS_LOAD = WCNT_W'(WAIT_STATES);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] ad_o_q, ad_o_d;
  logic              ad_lo_oe_q, ad_lo_oe_d;
  logic              ad_hi_oe_q, ad_hi_oe_d;
  logic              ale_q, ale_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              pio_q, pio_d;
  logic              accept_s;
  logic              strobe_s;
  logic              wc_load_s, wc_dec_s, wc_zero_s;

  mbus_wait_cnt u_wait_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (wc_load_s),
    .load_val (WS_LOAD),
    .dec      (wc_dec_s),
    .zero     (wc_zero_s)
  );

  // Next state, request capture, and the bus outputs implied by the next state.
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    wc_load_s = 1'b0;
    wc_dec_s  = 1'b0;
    accept_s  = bus.req && ((state_q == ST_IDLE) || (state_q == ST_T4));

    case (state_q)
      ST_IDLE: state_d = accept_s ? ST_T1 : ST_IDLE;
      ST_T1:   state_d = ST_T2;
      ST_T2: begin
        state_d   = ST_T3;
        wc_load_s = 1'b1;
      end
      ST_T3: begin
        if (wc_zero_s) begin
          state_d = ST_T4;
          rdata_d = we_q ? rdata_q : bus.ad_i;
        end else begin
          state_d  = ST_T3;
          wc_dec_s = 1'b1;
        end
      end
      ST_T4:   state_d = accept_s ? ST_T1 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (accept_s) begin
      we_d    = bus.req_we;
      addr_d  = bus.req_addr;
      wdata_d = bus.req_wdata;
    end else begin
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
    end

    // Outputs are derived from the state being entered so they register cleanly.
    strobe_s   = (state_d == ST_T3);
    busy_d     = (state_d == ST_T1) || (state_d == ST_T2) || (state_d == ST_T3);
    done_d     = (state_d == ST_T4);
    ale_d      = (state_d == ST_T1);
    oe_n_d     = !strobe_s;
    pio_d      = strobe_s;
    we_n_d     = !(strobe_s && we_d);
    ad_hi_oe_d = (state_d != ST_IDLE);
    ad_lo_oe_d = (state_d == ST_T1) || ((state_d != ST_IDLE) && we_d);

    case (state_d)
      ST_IDLE: ad_o_d = {ADDR_W{1'b0}};
      ST_T1:   ad_o_d = addr_d;
      default: ad_o_d = {addr_d[19:16], (we_d ? wdata_d : addr_d[15:0])};
    endcase
  end

  // State, captured request and registered bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      addr_q     <= {ADDR_W{1'b0}};
      wdata_q    <= {DATA_W{1'b0}};
      rdata_q    <= {DATA_W{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ad_o_q     <= {ADDR_W{1'b0}};
      ad_lo_oe_q <= 1'b0;
      ad_hi_oe_q <= 1'b0;
      ale_q      <= 1'b0;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      pio_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ad_o_q     <= ad_o_d;
      ad_lo_oe_q <= ad_lo_oe_d;
      ad_hi_oe_q <= ad_hi_oe_d;
      ale_q      <= ale_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      pio_q      <= pio_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rdata    = rdata_q;
  assign bus.ad_o     = ad_o_q;
  assign bus.ad_lo_oe = ad_lo_oe_q;
  assign bus.ad_hi_oe = ad_hi_oe_q;
  assign bus.ale      = ale_q;
  assign bus.oe_n     = oe_n_q;
  assign bus.we_n     = we_n_q;
  assign bus.pio      = pio_q;

endmodule

// File: tb/tb_mbus_master.sv
// Bench: two masters (WAIT_STATES 0 and 1) share one stimulus stream; a cycle-count model checks both.
module tb_mbus_master;
  import mbus_pkg::*;

  localparam int WS0 = 0;
  localparam int WS1 = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        req_we = 1'b0;
  logic [19:0] req_addr = 20'h0;
  logic [15:0] req_wdata = 16'h0;
  logic [15:0] ad_i = 16'h0BAD;
  logic [15:0] exp_wd = 16'h0;

  mbus_if if0 ();
  mbus_if if1 ();

  assign if0.req = req;  assign if0.req_we = req_we;  assign if0.req_addr = req_addr;
  assign if0.req_wdata = req_wdata;  assign if0.ad_i = ad_i;
  assign if1.req = req;  assign if1.req_we = req_we;  assign if1.req_addr = req_addr;
  assign if1.req_wdata = req_wdata;  assign if1.ad_i = ad_i;

  mbus_master #(.WAIT_STATES(WS0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  mbus_master #(.WAIT_STATES(WS1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  always #5 clk = ~clk;

  logic        busy_o[2], done_o[2], lo_o[2], hi_o[2], ale_o[2], oe_n_o[2], we_n_o[2], pio_o[2];
  logic [19:0] ad_o_o[2];
  logic [15:0] rdata_o[2];
  assign busy_o[0] = if0.busy;  assign done_o[0] = if0.done;  assign lo_o[0] = if0.ad_lo_oe;
  assign hi_o[0] = if0.ad_hi_oe;  assign ale_o[0] = if0.ale;  assign oe_n_o[0] = if0.oe_n;
  assign we_n_o[0] = if0.we_n;  assign pio_o[0] = if0.pio;  assign ad_o_o[0] = if0.ad_o;
  assign rdata_o[0] = if0.rdata;
  assign busy_o[1] = if1.busy;  assign done_o[1] = if1.done;  assign lo_o[1] = if1.ad_lo_oe;
  assign hi_o[1] = if1.ad_hi_oe;  assign ale_o[1] = if1.ale;  assign oe_n_o[1] = if1.oe_n;
  assign we_n_o[1] = if1.we_n;  assign pio_o[1] = if1.pio;  assign ad_o_o[1] = if1.ad_o;
  assign rdata_o[1] = if1.rdata;

  int n_vec = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int inst, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s [ws%0d] got=%0h expected=%0h at %0t", name, inst, got, exp, $time);
    end
  endtask

  function automatic int cyc_len(input int i);
    return 4 + ((i == 0) ? WS0 : WS1);
  endfunction

  // Model: each transaction is numbered cycle 1..len after acceptance; len = 4 + wait states.
  logic        m_act[2] = '{1'b0, 1'b0};
  int          m_k[2] = '{0, 0};
  logic        m_we[2] = '{1'b0, 1'b0};
  logic [19:0] m_addr[2] = '{20'h0, 20'h0};
  logic [15:0] m_wd[2] = '{16'h0, 16'h0};
  logic [15:0] m_rd[2] = '{16'h0, 16'h0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] <= 1'b0; m_k[i] <= 0; m_we[i] <= 1'b0;
        m_addr[i] <= 20'h0; m_wd[i] <= 16'h0; m_rd[i] <= 16'h0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_act[i] && (m_k[i] != cyc_len(i))) begin
          m_k[i] <= m_k[i] + 1;
          if ((m_k[i] == cyc_len(i) - 1) && !m_we[i]) m_rd[i] <= ad_i;
        end else if (req) begin
          m_act[i] <= 1'b1; m_k[i] <= 1;
          m_we[i] <= req_we; m_addr[i] <= req_addr; m_wd[i] <= req_wdata;
        end else begin
          m_act[i] <= 1'b0; m_k[i] <= 0;
        end
      end
    end
  end

  task automatic compare_inst(input int i);
    logic a, strobe;
    int   k, len;
    a      = m_act[i];
    k      = m_k[i];
    len    = cyc_len(i);
    strobe = a && (k >= 3) && (k < len);
    chk("busy",  i, 32'(busy_o[i]), 32'(a && (k < len)));
    chk("done",  i, 32'(done_o[i]), 32'(a && (k == len)));
    chk("ale",   i, 32'(ale_o[i]),  32'(a && (k == 1)));
    chk("oe_n",  i, 32'(oe_n_o[i]), 32'(!strobe));
    chk("pio",   i, 32'(pio_o[i]),  32'(strobe));
    chk("we_n",  i, 32'(we_n_o[i]), 32'(!(strobe && m_we[i])));
    chk("hi_oe", i, 32'(hi_o[i]),   32'(a));
    chk("lo_oe", i, 32'(lo_o[i]),   32'(a && ((k == 1) || m_we[i])));
    chk("rdata", i, 32'(rdata_o[i]), 32'(m_rd[i]));
    if (a) begin
      chk("ad_hi", i, 32'(ad_o_o[i][19:16]), 32'(m_addr[i][19:16]));
      if (k == 1) chk("ad_lo_addr", i, 32'(ad_o_o[i][15:0]), 32'(m_addr[i][15:0]));
      else if (m_we[i]) chk("ad_lo_data", i, 32'(ad_o_o[i][15:0]), 32'(m_wd[i]));
    end
  endtask

  initial begin : cmp
    forever begin
      @(negedge clk);
      compare_inst(0);
      compare_inst(1);
    end
  end

  int          ale_cnt[2], oen_cnt[2], wen_cnt[2], done_cnt[2], first_done[2], last_done[2];
  int          lo_low[2], wd_cnt[2];
  logic [19:0] ale_addr[2];
  logic [15:0] rd_done[2];

  task automatic record(input int i, input int c);
    if (ale_o[i]) begin ale_cnt[i]++; ale_addr[i] = ad_o_o[i]; end
    if (!oe_n_o[i]) oen_cnt[i]++;
    if (!we_n_o[i]) wen_cnt[i]++;
    if (done_o[i]) begin
      done_cnt[i]++;
      last_done[i] = c;
      if (first_done[i] == 0) begin first_done[i] = c; rd_done[i] = rdata_o[i]; end
    end
    if ((busy_o[i] || done_o[i]) && !lo_o[i]) lo_low[i]++;
    if ((busy_o[i] || done_o[i]) && !ale_o[i] && (ad_o_o[i][15:0] == exp_wd)) wd_cnt[i]++;
  endtask

  task automatic start(input logic we, input logic [19:0] addr, input logic [15:0] wd);
    @(posedge clk); #2;
    req = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; exp_wd = wd;
    @(posedge clk);
  endtask

  // Cycle c is the negedge after the c-th edge following acceptance.
  task automatic observe(input int ncyc, input int drop_at, input int pulse_at, input int ai_on);
    for (int i = 0; i < 2; i++) begin
      ale_cnt[i] = 0; oen_cnt[i] = 0; wen_cnt[i] = 0; done_cnt[i] = 0; first_done[i] = 0;
      last_done[i] = 0; lo_low[i] = 0; wd_cnt[i] = 0; ale_addr[i] = 20'h0; rd_done[i] = 16'h0;
    end
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      record(0, c);
      record(1, c);
      if (c == drop_at) begin req = 1'b0; req_addr = 20'h5A5A5; req_wdata = 16'h1234; end
      if (c == pulse_at) begin req = 1'b1; req_we = 1'b0; req_addr = 20'hFFFFF; req_wdata = 16'h0000; end
      if ((pulse_at != 0) && (c == pulse_at + 1)) req = 1'b0;
      if (c == ai_on) ad_i = 16'hBEEF;
      if ((ai_on != 0) && (c == ai_on + 3)) ad_i = 16'hDEAD;
    end
  endtask

  initial begin : stim
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 1, 32'(busy_o[1]), 32'h0);
    chk("rst_done", 1, 32'(done_o[1]), 32'h0);
    chk("rst_rdata", 1, 32'(rdata_o[1]), 32'h0);
    chk("rst_ad_o", 1, 32'(ad_o_o[1]), 32'h0);
    chk("rst_lo_oe", 1, 32'(lo_o[1]), 32'h0);
    chk("rst_hi_oe", 1, 32'(hi_o[1]), 32'h0);
    chk("rst_ale", 1, 32'(ale_o[1]), 32'h0);
    chk("rst_oe_n", 1, 32'(oe_n_o[1]), 32'h1);
    chk("rst_we_n", 1, 32'(we_n_o[1]), 32'h1);
    chk("rst_pio", 1, 32'(pio_o[1]), 32'h0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    // Read of 0x30012, ad_i = BEEF across the strobe window.
    start(1'b0, 20'h30012, 16'h0000);
    observe(8, 1, 0, 2);
    chk("s1_ale_cnt", 1, 32'(ale_cnt[1]), 32'd1);
    chk("s1_ale_addr", 1, 32'(ale_addr[1]), 32'h30012);
    chk("s1_oen_cnt", 1, 32'(oen_cnt[1]), 32'd2);
    chk("s1_done_cyc", 1, 32'(first_done[1]), 32'd5);
    chk("s1_rdata", 1, 32'(rd_done[1]), 32'hBEEF);
    chk("s1_lo_low", 1, 32'(lo_low[1]), 32'd4);
    chk("s5_oen_cnt", 0, 32'(oen_cnt[0]), 32'd1);
    chk("s5_done_cyc", 0, 32'(first_done[0]), 32'd4);
    chk("s5_rdata", 0, 32'(rd_done[0]), 32'hBEEF);

    // Write of A55A to 0x00034.
    start(1'b1, 20'h00034, 16'hA55A);
    observe(8, 1, 0, 0);
    chk("s2_ale_addr", 1, 32'(ale_addr[1]), 32'h00034);
    chk("s2_wdata_cyc", 1, 32'(wd_cnt[1]), 32'd4);
    chk("s2_wen_cnt", 1, 32'(wen_cnt[1]), 32'd2);
    chk("s2_oen_cnt", 1, 32'(oen_cnt[1]), 32'd2);
    chk("s2_lo_low", 1, 32'(lo_low[1]), 32'd0);
    chk("s2_done_cyc", 1, 32'(first_done[1]), 32'd5);
    chk("s2_wdata_cyc", 0, 32'(wd_cnt[0]), 32'd3);
    chk("s2_wen_cnt", 0, 32'(wen_cnt[0]), 32'd1);

    // req held high: three back-to-back reads.
    ad_i = 16'h7E57;
    start(1'b0, 20'hF0100, 16'h0000);
    observe(18, 11, 0, 0);
    chk("s3_done_cnt", 1, 32'(done_cnt[1]), 32'd3);
    chk("s3_first_done", 1, 32'(first_done[1]), 32'd5);
    chk("s3_last_done", 1, 32'(last_done[1]), 32'd15);
    chk("s3_ale_cnt", 1, 32'(ale_cnt[1]), 32'd3);
    chk("s3_done_cnt", 0, 32'(done_cnt[0]), 32'd3);
    chk("s3_first_done", 0, 32'(first_done[0]), 32'd4);
    chk("s3_last_done", 0, 32'(last_done[0]), 32'd12);
    chk("s3_rdata", 0, 32'(rd_done[0]), 32'h7E57);

    // req pulsed while busy must not disturb the captured write.
    start(1'b1, 20'hC1234, 16'h0F0F);
    observe(8, 1, 2, 0);
    chk("s6_done_cnt", 1, 32'(done_cnt[1]), 32'd1);
    chk("s6_ale_cnt", 1, 32'(ale_cnt[1]), 32'd1);
    chk("s6_ale_addr", 1, 32'(ale_addr[1]), 32'hC1234);
    chk("s6_wdata_cyc", 1, 32'(wd_cnt[1]), 32'd4);
    chk("s6_done_cnt", 0, 32'(done_cnt[0]), 32'd1);

    // Reset during the strobe of a write.
    start(1'b1, 20'h00077, 16'h3C3C);
    #2 req = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    chk("s4_pre_we_n", 1, 32'(we_n_o[1]), 32'h0);
    chk("s4_pre_we_n", 0, 32'(we_n_o[0]), 32'h0);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("s4_we_n", i, 32'(we_n_o[i]), 32'h1);
      chk("s4_oe_n", i, 32'(oe_n_o[i]), 32'h1);
      chk("s4_lo_oe", i, 32'(lo_o[i]), 32'h0);
      chk("s4_hi_oe", i, 32'(hi_o[i]), 32'h0);
      chk("s4_pio", i, 32'(pio_o[i]), 32'h0);
      chk("s4_busy", i, 32'(busy_o[i]), 32'h0);
    end
    @(negedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    observe(8, 0, 0, 0);
    chk("s4_no_done", 1, 32'(done_cnt[1]), 32'd0);
    chk("s4_no_done", 0, 32'(done_cnt[0]), 32'd0);
    start(1'b1, 20'h00088, 16'h6969);
    observe(8, 1, 0, 0);
    chk("s4_next_done", 1, 32'(first_done[1]), 32'd5);
    chk("s4_next_ale", 1, 32'(ale_addr[1]), 32'h00088);
    chk("s4_next_wd", 1, 32'(wd_cnt[1]), 32'd4);
    chk("s4_next_done", 0, 32'(first_done[0]), 32'd4);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mbus_master.md
MBUS_MASTER -- requirements
Module: mbus_master

Interface
REQ-001 Parameter WAIT_STATES, default 1, sets the number of extra T3 cycles inserted before read sampling or write release (0..15).
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 req  in  1  core request, qualified by !busy.
REQ-005 req_we  in  1  1 = write, 0 = read; sampled with req.
REQ-006 req_addr  in  20  word address; [19:16] is the upper nibble, [15:0] is the muxed part.
REQ-007 req_wdata  in  16  write data; [15:8] is the high byte lane, [7:0] is the low byte lane.
REQ-008 busy  out  1  cycle in progress; req is ignored while high.
REQ-009 done  out  1  one-cycle pulse at cycle end.
REQ-010 rdata  out  16  read data, valid while done is high and held until the next read completes.
REQ-011 ad_o  out  20  bus drive value for io1..io20.
REQ-012 ad_i  in  16  sampled muxed bus io1..io16.
REQ-013 ad_lo_oe  out  1  tri-state enable for ad_o[15:0].
REQ-014 ad_hi_oe  out  1  tri-state enable for ad_o[19:16].
REQ-015 ale  out  1  address latch enable, active-high; external latches close on its falling edge.
REQ-016 oe_n  out  1  transceiver enable, active-low.
REQ-017 we_n  out  1  write strobe and transceiver direction; 1 = memory to bus.
REQ-018 pio  out  1  chip-select decoder enable, active-high.

Function
REQ-019 The FSM SHALL have states IDLE, T1, T2, T3, T4.
REQ-020 IDLE SHALL accept req and capture req_we, req_addr and req_wdata into internal registers.
REQ-021 On acceptance the FSM SHALL move to T1 and raise busy.
REQ-022 T1 SHALL drive ad_o = captured address, ad_lo_oe = ad_hi_oe = 1 and ale = 1.
REQ-023 T2 SHALL drive ale = 0.
REQ-024 In T2, ad_o[19:16] SHALL be held.
REQ-025 In T2, a write SHALL drive ad_o[15:0] = wdata.
REQ-026 In T2, a read SHALL release ad_lo_oe to 0 as a turnaround cycle.
REQ-027 T3 SHALL assert oe_n = 0 and pio = 1.
REQ-028 T3 SHALL assert we_n = 0 for a write.
REQ-029 T3 SHALL last 1 + WAIT_STATES cycles, counted by a 4-bit wait counter.
REQ-030 A read SHALL load rdata from ad_i on the rising edge that ends the final T3 cycle.
REQ-031 T4 SHALL deassert oe_n, we_n and pio.
REQ-032 In T4, a write SHALL hold ad_o[15:0] for data hold time.
REQ-033 In T4, a read SHALL keep ad_lo_oe = 0.
REQ-034 T4 SHALL pulse done.
REQ-035 From T4 the FSM SHALL go to T1 if req is high, otherwise to IDLE.
REQ-036 busy SHALL be high during T1..T3 and low in T4, so a back-to-back req in T4 is accepted.
REQ-037 ad_hi_oe SHALL stay 1 from T1 through T4 so that the decoder select bits io18..io20 are stable while pio is high.
REQ-038 ale and oe_n/pio SHALL never be asserted in the same cycle.
REQ-039 we_n SHALL never be 0 while ad_lo_oe is 0.
REQ-040 A read cycle SHALL take 4 + WAIT_STATES cycles; a write cycle SHALL take the same.
REQ-041 All bus outputs SHALL be registered, with no combinational path from req to the bus.

Reset
REQ-042 rst_n low SHALL immediately force state IDLE, busy = 0, done = 0 and rdata = 0.
REQ-043 rst_n low SHALL immediately force ad_o = 0, ad_lo_oe = ad_hi_oe = 0, ale = 0, oe_n = 1, we_n = 1 and pio = 0.
REQ-044 Reset asserted mid-cycle SHALL abort the cycle with no done pulse.
REQ-045 The first req after reset release SHALL start a fresh T1.

Structure
REQ-046 A shared package mbus_pkg SHALL hold the state enumeration, the address and data widths (20/16) and the WAIT_STATES counter width.
REQ-047 The wait-state counter SHALL be a natural sub-module, mbus_wait_cnt (load, decrement, zero flag).
REQ-048 All other logic SHALL be inline.

Verification
REQ-049 Scenario 1: WAIT_STATES=1, read of 0x30012 with ad_i=0xBEEF during T3 -> ale high exactly one cycle with ad_o=0x30012; oe_n low for 2 cycles; done after 5 cycles; rdata=0xBEEF.
REQ-050 Scenario 2: write of 0x00034 with data 0xA55A -> ad_o[15:0]=0xA55A from T2 through T4; we_n low only in T3; ad_lo_oe=1 throughout.
REQ-051 Scenario 3: req held high for 3 reads -> consecutive T1s with no IDLE gap; exactly 3 done pulses; each cycle 4+WAIT_STATES long.
REQ-052 Scenario 4: rst_n pulsed low during T3 of a write -> we_n=1, oe_n=1 and all oe=0 asynchronously; no done pulse; the next req completes normally.
REQ-053 Scenario 5: WAIT_STATES=0 read -> T3 lasts 1 cycle; done in cycle 4; sampling happens in the single T3 cycle.
REQ-054 Scenario 6: req asserted while busy -> ignored, with no change to the captured address or data.
